// File: rtl/rf_access_seq.sv
// Command-driven DUMP/FILL/COPY sequencer for the 32x32 three-port register file.
// Drives read port 1 (A1/RD1) and the write port (A3/WD3/WE3); read port 2 is untouched.
module rf_access_seq (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        CMD_VALID,
  output logic        CMD_READY,
  input  logic [1:0]  CMD_OP,
  input  logic [4:0]  CMD_FIRST,
  input  logic [4:0]  CMD_LAST,
  input  logic [31:0] CMD_DATA,
  input  logic        ABORT,
  output logic [4:0]  A1,
  input  logic [31:0] RD1,
  output logic [4:0]  A3,
  output logic [31:0] WD3,
  output logic        WE3,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [31:0] OUT_DATA,
  output logic [4:0]  OUT_ADDR,
  output logic        OUT_LAST,
  output logic        BUSY,
  output logic        DONE
);

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 6;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_DUMP = 3'd1,
    S_FILL = 3'd2,
    S_COPY = 3'd3,
    S_FIN  = 3'd4
  } state_t;

  state_t          state;
  logic [AW-1:0]   ptr;
  logic [AW-1:0]   dst;
  logic [CW-1:0]   cnt;
  logic [DW-1:0]   fill_q;
  logic            out_valid_q;
  logic            out_last_q;
  logic [DW-1:0]   out_data_q;
  logic [AW-1:0]   out_addr_q;

  logic [AW-1:0]   span;
  logic            last_step;
  logic            dump_load;

  // 5-bit wrap of LAST-FIRST gives the modular range length minus one
  assign span      = CMD_LAST - CMD_FIRST;
  assign last_step = (cnt == CW'(1));
  assign dump_load = (!out_valid_q || OUT_READY) && (cnt != '0);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= S_IDLE;
      ptr         <= '0;
      dst         <= '0;
      cnt         <= '0;
      fill_q      <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (CMD_VALID) begin
            ptr    <= CMD_FIRST;
            dst    <= CMD_DATA[AW-1:0];
            cnt    <= CW'(span) + CW'(1);
            fill_q <= CMD_DATA;
            case (CMD_OP)
              2'b00:   state <= S_DUMP;
              2'b01:   state <= S_FILL;
              2'b10:   state <= S_COPY;
              default: state <= S_FIN;
            endcase
          end
        end
        S_DUMP: begin
          if (ABORT) begin
            out_valid_q <= 1'b0;
            state       <= S_FIN;
          end else if (dump_load) begin
            out_valid_q <= 1'b1;
            out_data_q  <= RD1;
            out_addr_q  <= ptr;
            out_last_q  <= last_step;
            ptr         <= ptr + AW'(1);
            cnt         <= cnt - CW'(1);
          end else if (out_valid_q && OUT_READY) begin
            // only reachable once the final word has been handed over
            out_valid_q <= 1'b0;
            if (out_last_q) state <= S_FIN;
          end
        end
        S_FILL, S_COPY: begin
          ptr <= ptr + AW'(1);
          dst <= dst + AW'(1);
          cnt <= cnt - CW'(1);
          if (ABORT || last_step) state <= S_FIN;
        end
        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign CMD_READY = (state == S_IDLE);
  assign BUSY      = (state != S_IDLE);
  assign DONE      = (state == S_FIN);
  assign A1        = (state == S_DUMP || state == S_COPY) ? ptr : '0;
  assign OUT_VALID = out_valid_q;
  assign OUT_DATA  = out_data_q;
  assign OUT_ADDR  = out_addr_q;
  assign OUT_LAST  = out_last_q;

  // Write port: x0 cycles and the abort cycle still consume a slot but never write
  always_comb begin
    A3  = '0;
    WD3 = '0;
    WE3 = 1'b0;
    case (state)
      S_FILL: begin
        A3  = ptr;
        WD3 = fill_q;
        WE3 = (ptr != '0) && !ABORT;
      end
      S_COPY: begin
        A3  = dst;
        WD3 = RD1;
        WE3 = (dst != '0) && !ABORT;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rf_access_seq.sv
// Bench for rf_access_seq: register-file model, directed scenarios and random commands
// checked against an array/queue model of the command semantics.
module tb_rf_access_seq;

  logic        CLK;
  logic        RST_N;
  logic        CMD_VALID;
  logic        CMD_READY;
  logic [1:0]  CMD_OP;
  logic [4:0]  CMD_FIRST;
  logic [4:0]  CMD_LAST;
  logic [31:0] CMD_DATA;
  logic        ABORT;
  logic [4:0]  A1;
  logic [31:0] RD1;
  logic [4:0]  A3;
  logic [31:0] WD3;
  logic        WE3;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [31:0] OUT_DATA;
  logic [4:0]  OUT_ADDR;
  logic        OUT_LAST;
  logic        BUSY;
  logic        DONE;

  rf_access_seq dut (
    .CLK(CLK), .RST_N(RST_N),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_OP(CMD_OP),
    .CMD_FIRST(CMD_FIRST), .CMD_LAST(CMD_LAST), .CMD_DATA(CMD_DATA),
    .ABORT(ABORT),
    .A1(A1), .RD1(RD1), .A3(A3), .WD3(WD3), .WE3(WE3),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA),
    .OUT_ADDR(OUT_ADDR), .OUT_LAST(OUT_LAST),
    .BUSY(BUSY), .DONE(DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Register file environment with a bench-side preload port
  logic [31:0] rf [32];
  logic        pre_we;
  logic [4:0]  pre_addr;
  logic [31:0] pre_data;
  logic [36:0] act_writes [$];

  assign RD1 = (A1 == 5'd0) ? 32'd0 : rf[A1];

  always @(posedge CLK) begin
    if (pre_we) rf[pre_addr] <= pre_data;
    if (WE3) begin
      act_writes.push_back({A3, WD3});
      if (A3 != 5'd0) rf[A3] <= WD3;
    end
  end

  // Reference register contents, updated per command
  logic [31:0] m [32];

  int n_tests;
  int n_fail;
  int done_cyc;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic preload(input logic [4:0] a, input logic [31:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(posedge CLK); #1;
    pre_we = 1'b0;
    m[a] = d;
  endtask

  task automatic chk_rf(input string tag);
    for (int i = 1; i < 32; i++) chk(tag, rf[i], m[i]);
  endtask

  task automatic chk_writes(input logic [36:0] exp_w [$]);
    chk("write_count", act_writes.size(), exp_w.size());
    for (int i = 0; i < exp_w.size() && i < act_writes.size(); i++)
      chk("write_entry", act_writes[i], exp_w[i]);
  endtask

  // Issue one command and follow it to DONE; rmode 0 ready high, 1 pattern 1,0,0, 2 random
  task automatic run_cmd(input logic [1:0] op, input logic [4:0] first, input logic [4:0] last,
                         input logic [31:0] data, input int abort_at, input int rmode,
                         output int dcyc);
    logic [37:0] exp_words [$];
    logic [36:0] exp_w [$];
    logic [37:0] held;
    logic [4:0]  a;
    logic [4:0]  d;
    int          cnt;
    int          n_act;
    int          n_words;
    int          done_seen;
    bit          prev_stall;

    cnt   = ((int'(last) - int'(first)) & 31) + 1;
    n_act = (abort_at >= 0 && abort_at < cnt) ? abort_at : cnt;
    act_writes.delete();
    case (op)
      2'b00: for (int i = 0; i < cnt; i++) begin
        a = 5'((int'(first) + i) & 31);
        exp_words.push_back({m[a], a, (i == cnt - 1)});
      end
      2'b01: for (int i = 0; i < n_act; i++) begin
        a = 5'((int'(first) + i) & 31);
        if (a != 5'd0) begin
          exp_w.push_back({a, data});
          m[a] = data;
        end
      end
      2'b10: for (int i = 0; i < n_act; i++) begin
        a = 5'((int'(first) + i) & 31);
        d = 5'((int'(data[4:0]) + i) & 31);
        if (d != 5'd0) begin
          exp_w.push_back({d, m[a]});
          m[d] = m[a];
        end
      end
      default: ;
    endcase

    chk("cmd_ready_idle", CMD_READY, 1);
    CMD_VALID = 1'b1; CMD_OP = op; CMD_FIRST = first; CMD_LAST = last; CMD_DATA = data;
    @(posedge CLK); #1;
    CMD_VALID = 1'b0;

    n_words = 0; done_seen = 0; dcyc = -1; prev_stall = 1'b0; held = '0;
    for (int cyc = 0; cyc < 400 && done_seen == 0; cyc++) begin
      if (prev_stall)
        chk("stall_hold", {OUT_VALID, OUT_ADDR, OUT_LAST, OUT_DATA}, {1'b1, held});
      ABORT = (cyc == abort_at);
      case (rmode)
        0:       OUT_READY = 1'b1;
        1:       OUT_READY = (cyc % 3 == 0);
        default: OUT_READY = 1'($urandom_range(0, 1));
      endcase
      if (OUT_VALID && OUT_READY && !ABORT) begin
        n_words++;
        if (exp_words.size() > 0)
          chk("dump_word", {OUT_DATA, OUT_ADDR, OUT_LAST}, exp_words.pop_front());
      end
      if (DONE) begin
        done_seen++;
        dcyc = cyc;
      end
      prev_stall = OUT_VALID && !OUT_READY && !ABORT;
      held = {OUT_ADDR, OUT_LAST, OUT_DATA};
      @(posedge CLK); #1;
      ABORT = 1'b0;
    end
    OUT_READY = 1'b1;

    chk("done_seen", done_seen, 1);
    chk("after_done", {DONE, CMD_READY, BUSY}, 3'b010);
    chk("dump_words", n_words, (op == 2'b00) ? cnt : 0);
    chk_writes(exp_w);
    chk_rf("rf_state");
  endtask

  initial begin
    logic [36:0] exp_w [$];

    n_tests = 0; n_fail = 0;
    RST_N = 1'b0; CMD_VALID = 1'b0; CMD_OP = '0; CMD_FIRST = '0; CMD_LAST = '0;
    CMD_DATA = '0; ABORT = 1'b0; OUT_READY = 1'b1;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    m[0] = 32'd0;

    repeat (2) @(posedge CLK);
    #1;
    chk("reset_ctl", {CMD_READY, BUSY, DONE, OUT_VALID, OUT_LAST, WE3, A1, A3, OUT_ADDR}, {1'b1, 20'd0});
    chk("reset_data", {WD3, OUT_DATA}, 64'd0);
    RST_N = 1'b1;

    for (int i = 1; i < 32; i++) preload(5'(i), $urandom);

    // Streaming dump at full rate
    preload(5'd1, 32'h11); preload(5'd2, 32'h22); preload(5'd3, 32'h33); preload(5'd4, 32'h44);
    run_cmd(2'b00, 5'd1, 5'd4, 32'd0, -1, 0, done_cyc);
    chk("dump_latency", done_cyc, 5);

    // Same dump with a stalling consumer
    run_cmd(2'b00, 5'd1, 5'd4, 32'd0, -1, 1, done_cyc);

    // Wrapping fill across x0
    run_cmd(2'b01, 5'd30, 5'd2, 32'hDEADBEEF, -1, 0, done_cyc);
    chk("fill_latency", done_cyc, 5);

    // Copy 5..7 to 20..22
    preload(5'd5, 32'd7); preload(5'd6, 32'd8); preload(5'd7, 32'd9);
    run_cmd(2'b10, 5'd5, 5'd7, 32'd20, -1, 0, done_cyc);
    chk("copy_latency", done_cyc, 3);

    // Full-range fill aborted in its fourth active cycle
    run_cmd(2'b01, 5'd0, 5'd31, 32'hCAFE0001, 3, 0, done_cyc);
    chk("abort_latency", done_cyc, 4);

    // Reserved op finishes without any access
    run_cmd(2'b11, 5'd3, 5'd9, 32'h5, -1, 0, done_cyc);
    chk("reserved_latency", done_cyc, 0);

    // Asynchronous reset in the middle of a copy
    act_writes.delete();
    exp_w.delete();
    for (int i = 0; i < 3; i++) begin
      exp_w.push_back({5'(24 + i), m[8 + i]});
      m[24 + i] = m[8 + i];
    end
    CMD_VALID = 1'b1; CMD_OP = 2'b10; CMD_FIRST = 5'd8; CMD_LAST = 5'd15; CMD_DATA = 32'd24;
    @(posedge CLK); #1;
    CMD_VALID = 1'b0;
    repeat (3) @(posedge CLK);
    #3;
    RST_N = 1'b0;
    #1;
    chk("midrst_ctl", {CMD_READY, BUSY, DONE, OUT_VALID, OUT_LAST, WE3, A1, A3, OUT_ADDR}, {1'b1, 20'd0});
    chk("midrst_data", {WD3, OUT_DATA}, 64'd0);
    @(posedge CLK); #1;
    RST_N = 1'b1;
    chk_writes(exp_w);
    chk_rf("midrst_rf");
    run_cmd(2'b10, 5'd1, 5'd3, 32'd12, -1, 0, done_cyc);
    chk("post_rst_latency", done_cyc, 3);

    // Random commands
    for (int k = 0; k < 30; k++)
      run_cmd(2'($urandom_range(0, 3)), 5'($urandom), 5'($urandom), $urandom, -1, 2, done_cyc);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

endmodule

// File: doc/rf_access_seq.md
Name: rf_access_seq

Overview:
- Command-driven initiator for the 32x32 three-port register file (2 combinational read ports, 1 synchronous write port, x0 reads as zero).
- Accepts one command at a time: DUMP streams a register range out over valid/ready; FILL writes a constant to a range; COPY moves a range to another base address.
- Sits between the debug/test controller and the register file's A1/RD1 read port and A3/WD3/WE3 write port. Read port 2 stays with the datapath.

Parameters:
- none (address width 5 and data width 32 are fixed to match the register file)

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RST_N  in  1  asynchronous, active-low reset
- CMD_VALID  in  1  command request
- CMD_READY  out  1  high when idle; a command is accepted on CMD_VALID & CMD_READY
- CMD_OP  in  2  00 DUMP, 01 FILL, 10 COPY, 11 reserved
- CMD_FIRST  in  5  first register of range
- CMD_LAST  in  5  last register of range (inclusive)
- CMD_DATA  in  32  FILL value; COPY destination base in bits [4:0]
- ABORT  in  1  synchronous abort of the active command
- A1  out  5  register file read address
- RD1  in  32  register file read data (combinational from A1)
- A3  out  5  register file write address
- WD3  out  32  register file write data
- WE3  out  1  register file write enable
- OUT_VALID  out  1  dump word valid
- OUT_READY  in  1  dump consumer ready
- OUT_DATA  out  32  dump word
- OUT_ADDR  out  5  register index of OUT_DATA
- OUT_LAST  out  1  OUT_DATA is the final word of the range
- BUSY  out  1  command in progress
- DONE  out  1  one-cycle pulse when a command finishes or is aborted

Behaviour:
- Reset (async, RST_N=0): state IDLE; ptr, count, dst = 0.
  - All outputs 0 except CMD_READY=1.
  - Reset mid-command truncates it immediately; no further WE3.
- States: IDLE, DUMP, FILL, COPY, FIN.
  - CMD_READY = (state==IDLE). BUSY = (state!=IDLE).
- Range: count = ((LAST-FIRST) mod 32) + 1, always 1..32.
  - ptr starts at FIRST and increments mod 32 (31 wraps to 0).
  - FIRST=LAST gives 1 register; FIRST=1, LAST=0 gives 32 registers.
- Command accept edge: latch op, FIRST, count and CMD_DATA; go to the op state.
  - Reserved op 11 goes to FIN directly: no accesses, DONE still pulses.
- A1 = ptr in DUMP and COPY, 0 otherwise.
- DUMP:
  - Output register loads RD1 (with OUT_ADDR=ptr, OUT_LAST=(remaining==1)) on any edge where (!OUT_VALID | OUT_READY) and words remain; ptr advances on load.
  - The first word is valid on the edge after command accept. Throughput is 1 word/cycle with OUT_READY held high.
  - OUT_DATA/ADDR/LAST stay stable while OUT_VALID & !OUT_READY.
  - After the OUT_LAST word is accepted: OUT_VALID=0, go to FIN.
  - WE3 stays 0 throughout.
- FILL:
  - One write per cycle: A3=ptr, WD3=fill value, WE3=1.
  - Address 0 is skipped: WE3=0 in that cycle, but the cycle and count are still consumed.
  - After the last write, go to FIN.
- COPY:
  - One register per cycle: A1=ptr, A3=dst, WD3=RD1 (same cycle), WE3=1. dst starts at CMD_DATA[4:0]; ptr and dst both increment mod 32.
  - dst=0 cycles write with WE3=0.
  - Order is always ascending. If the ranges overlap with dst>src, smeared data is the defined result.
- FIN: DONE=1 for exactly one cycle, then IDLE. BUSY stays 1 in FIN.
- ABORT (sampled when state is DUMP, FILL or COPY): the next edge goes to FIN.
  - WE3 is forced 0 in the abort cycle.
  - OUT_VALID is cleared even if no handshake occurred.
  - ABORT is ignored in IDLE and FIN.
- WE3, A3 and WD3 are registered-free functions of state/ptr/RD1 and are 0 outside FILL and COPY.

Test Plan:
- Preload R1..R4 = 0x11,0x22,0x33,0x44; DUMP FIRST=1 LAST=4, OUT_READY=1 -> 4 consecutive words 0x11..0x44 with OUT_ADDR 1..4, OUT_LAST only on 0x44, DONE one cycle after that word, CMD_READY back to 1.
- DUMP 1..4 with OUT_READY toggling 1,0,0,1,... -> no words lost or duplicated; OUT_DATA stable while stalled.
- FILL FIRST=30 LAST=2 DATA=0xDEADBEEF -> writes to 30,31,1,2; address 0 never written (WE3=0 in that cycle); DONE after the 5th cycle.
- Preload R5..R7 = 7,8,9; COPY FIRST=5 LAST=7 DATA=20 -> R20..R22 = 7,8,9; R5..R7 unchanged.
- FILL 0..31 with ABORT asserted in the 4th active cycle -> only 2 writes land (regs 1,2); no WE3 afterwards; DONE pulses once.
- RST_N low during COPY -> all outputs 0 and CMD_READY=1 immediately, without waiting for CLK; the next command executes normally.
